// File: rtl/mimc_mp_hash.sv
// Miyaguchi-Preneel hash h_i = E_{h_{i-1}}(m_i) + h_{i-1} + m_i (mod PRIME) around an
// iterative MiMC-7 cipher (x <- (x + key + r)^7 per round r, out = x + key).

module mimc_cipher #(
    parameter int unsigned N_BITS = 254,
    parameter logic [N_BITS-1:0] PRIME = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int unsigned N_ROUNDS = 91,
    parameter GALOIS_MULT_METHOD = "peasant",
    parameter GALOIS_POW_7_METHOD = "parallel",
    parameter MIMC_CIPHER_ROUND_METHOD = "v2"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] in,
    input  logic [N_BITS-1:0] key,
    output logic [N_BITS-1:0] out,
    output logic              done
);
    localparam int unsigned BW = $clog2(N_BITS);
    localparam int unsigned RW = $clog2(N_ROUNDS + 1);

    if (GALOIS_MULT_METHOD != "peasant" || GALOIS_POW_7_METHOD != "parallel" ||
        MIMC_CIPHER_ROUND_METHOD != "v2") begin : g_bad_method
        $error("mimc_cipher: unsupported method selection");
    end

    typedef enum logic [2:0] {C_IDLE, C_ROUND, C_MUL, C_FIN, C_DONE} cstate_t;

    cstate_t           state;
    logic [N_BITS-1:0] x, base, sq, p3, p4, acc0, acc1;
    logic [N_BITS-1:0] op0_a, op0_b, op1_a, op1_b, acc0_next, acc1_next;
    logic [BW-1:0]     bit_idx;
    logic [RW-1:0]     round;
    logic [1:0]        stage;

    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
        return s[N_BITS-1:0];
    endfunction

    function automatic logic [N_BITS-1:0] mul_step(input logic [N_BITS-1:0] acc, input logic [N_BITS-1:0] a,
                                                  input logic b_bit);
        return mod_add(mod_add(acc, acc), b_bit ? a : '0);
    endfunction

    // x^7 in three multiply slots: a^2, then a^3 and a^4 side by side, then a^3 * a^4
    always_comb begin
        op0_a = base;
        op0_b = base;
        op1_a = sq;
        op1_b = sq;
        case (stage)
            2'd1:    op0_a = sq;
            2'd2: begin
                op0_a = p3;
                op0_b = p4;
            end
            default: ;
        endcase
        acc0_next = mul_step(acc0, op0_a, op0_b[bit_idx]);
        acc1_next = mul_step(acc1, op1_a, op1_b[bit_idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= C_IDLE;
            x       <= '0;
            base    <= '0;
            sq      <= '0;
            p3      <= '0;
            p4      <= '0;
            acc0    <= '0;
            acc1    <= '0;
            out     <= '0;
            done    <= 1'b0;
            bit_idx <= '0;
            round   <= '0;
            stage   <= '0;
        end else if (en) begin
            case (state)
                C_IDLE: begin
                    x     <= in;
                    round <= '0;
                    state <= C_ROUND;
                end
                C_ROUND: begin
                    base    <= mod_add(mod_add(x, key), N_BITS'(round));
                    stage   <= '0;
                    bit_idx <= BW'(N_BITS - 1);
                    acc0    <= '0;
                    acc1    <= '0;
                    state   <= C_MUL;
                end
                C_MUL: begin
                    acc0 <= acc0_next;
                    acc1 <= acc1_next;
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                    end else begin
                        acc0    <= '0;
                        acc1    <= '0;
                        bit_idx <= BW'(N_BITS - 1);
                        stage   <= stage + 2'd1;
                        case (stage)
                            2'd0: sq <= acc0_next;
                            2'd1: begin
                                p3 <= acc0_next;
                                p4 <= acc1_next;
                            end
                            default: begin
                                x     <= acc0_next;
                                round <= round + 1'b1;
                                state <= (round == RW'(N_ROUNDS - 1)) ? C_FIN : C_ROUND;
                            end
                        endcase
                    end
                end
                C_FIN: begin
                    out   <= mod_add(x, key);
                    done  <= 1'b1;
                    state <= C_DONE;
                end
                default: ;
            endcase
        end
    end
endmodule

module mimc_mp_hash #(
    parameter int unsigned N_BITS = 254,
    parameter logic [N_BITS-1:0] PRIME = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter GALOIS_MULT_METHOD = "peasant",
    parameter GALOIS_POW_7_METHOD = "parallel",
    parameter MIMC_CIPHER_ROUND_METHOD = "v2",
    parameter int unsigned N_ROUNDS = 91
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [N_BITS-1:0] msg_data,
    input  logic              msg_last,
    output logic              hash_valid,
    input  logic              hash_ready,
    output logic [N_BITS-1:0] hash_out
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, ACC1, ACC2, OUT} state_t;

    state_t            state;
    logic [N_BITS-1:0] h, m, c, msg_reduced, cipher_out;
    logic              last, cipher_rst, cipher_en, cipher_done;

    function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
        return s[N_BITS-1:0];
    endfunction

    assign msg_reduced = (msg_data >= PRIME) ? msg_data - PRIME : msg_data;

    mimc_cipher #(
        .N_BITS                  (N_BITS),
        .PRIME                   (PRIME),
        .N_ROUNDS                (N_ROUNDS),
        .GALOIS_MULT_METHOD      (GALOIS_MULT_METHOD),
        .GALOIS_POW_7_METHOD     (GALOIS_POW_7_METHOD),
        .MIMC_CIPHER_ROUND_METHOD(MIMC_CIPHER_ROUND_METHOD)
    ) u_cipher (
        .clk (clk),
        .rst (cipher_rst),
        .en  (cipher_en),
        .in  (m),
        .key (h),
        .out (cipher_out),
        .done(cipher_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            h          <= '0;
            m          <= '0;
            c          <= '0;
            last       <= 1'b0;
            cipher_rst <= 1'b1;
            cipher_en  <= 1'b0;
            msg_ready  <= 1'b0;
            hash_valid <= 1'b0;
            hash_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (msg_valid && msg_ready) begin
                        m         <= msg_reduced;
                        last      <= msg_last;
                        msg_ready <= 1'b0;
                        state     <= LOAD;
                    end else begin
                        msg_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    cipher_rst <= 1'b0;
                    cipher_en  <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    if (cipher_done) begin
                        c          <= cipher_out;
                        cipher_en  <= 1'b0;
                        cipher_rst <= 1'b1;
                        state      <= ACC1;
                    end
                end
                // c is reused to hold t = c + h
                ACC1: begin
                    c     <= mod_add(c, h);
                    state <= ACC2;
                end
                ACC2: begin
                    h <= mod_add(c, m);
                    if (last) begin
                        hash_valid <= 1'b1;
                        hash_out   <= mod_add(c, m);
                        state      <= OUT;
                    end else begin
                        msg_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                OUT: begin
                    if (hash_ready) begin
                        h          <= '0;
                        hash_valid <= 1'b0;
                        hash_out   <= '0;
                        msg_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mimc_mp_hash.sv
// Self-checking bench for mimc_mp_hash: vector table plus hand-written backpressure and
// mid-message reset sequences, all checked against a modular-arithmetic reference model.

module tb_mimc_mp_hash;
    localparam int N = 254;
    localparam logic [N-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam int ROUNDS = 2;
    localparam int BOUND = 20000;
    localparam logic [N-1:0] TEST_IN  = 254'h2d1e5f3c0a9b8c7d6e5f4a3b2c1d0e9f8a7b6c5d4e3f2a1b0c9d8e7f6a5b4c3d;
    localparam logic [N-1:0] TEST_KEY = 254'h1a2b3c4d5e6f708192a3b4c5d6e7f8091a2b3c4d5e6f708192a3b4c5d6e7f809;

    logic         clk = 1'b0;
    logic         rst;
    logic         msg_valid;
    logic         msg_ready;
    logic [N-1:0] msg_data;
    logic         msg_last;
    logic         hash_valid;
    logic         hash_ready;
    logic [N-1:0] hash_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int l4 = 0;

    mimc_mp_hash #(.N_ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data),
        .msg_last  (msg_last),
        .hash_valid(hash_valid),
        .hash_ready(hash_ready),
        .hash_out  (hash_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] addmod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = s % {1'b0, P};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] prod;
        prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        prod = prod % {{N{1'b0}}, P};
        return prod[N-1:0];
    endfunction

    function automatic logic [N-1:0] pow7(input logic [N-1:0] a);
        logic [N-1:0] r;
        r = 1;
        for (int i = 0; i < 7; i++) r = mulmod(r, a);
        return r;
    endfunction

    function automatic logic [N-1:0] enc(input logic [N-1:0] x_in, input logic [N-1:0] k);
        logic [N-1:0] x;
        x = x_in;
        for (int r = 0; r < ROUNDS; r++) x = pow7(addmod(addmod(x, k), N'(r)));
        return addmod(x, k);
    endfunction

    function automatic logic [N-1:0] hash_of(input logic [2:0][N-1:0] blks, input int nblk);
        logic [N-1:0] h, mm;
        h = '0;
        for (int i = 0; i < nblk; i++) begin
            mm = blks[i] % P;
            h = addmod(addmod(enc(mm, h), h), mm);
        end
        return h;
    endfunction

    function automatic logic [N-1:0] rand_fe();
        logic [255:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[N-1:0];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [N-1:0] d, input logic l, output int acc);
        int n;
        n = 0;
        msg_valid = 1'b1;
        msg_data  = d;
        msg_last  = l;
        while (!msg_ready && n < BOUND) begin
            tick();
            n++;
        end
        check_int("accept within bound", int'(n < BOUND), 1);
        tick();
        acc = cyc;
        msg_valid = 1'b0;
        msg_data  = '0;
        msg_last  = 1'b0;
    endtask

    task automatic run_message(input string nm, input logic [2:0][N-1:0] blks, input int nblk,
                               input logic [N-1:0] exp, input bit handshake);
        int first_acc, acc, n, lat;
        bit zero_bad, rdy_bad, hv_bad;
        first_acc = 0;
        for (int i = 0; i < nblk; i++) begin
            send_block(blks[i], (i == nblk - 1), acc);
            if (i == 0) first_acc = acc;
            n = 0;
            zero_bad = 0;
            rdy_bad = 0;
            hv_bad = 0;
            if (i != nblk - 1) begin
                while (!msg_ready && n < BOUND) begin
                    if (hash_valid !== 1'b0) hv_bad = 1;
                    tick();
                    n++;
                end
                check_int({nm, " hash_valid low between blocks"}, int'(hv_bad), 0);
                if (l4 != 0) check_int({nm, " msg_ready low gap"}, n, l4);
            end else begin
                while (!hash_valid && n < BOUND) begin
                    if (hash_out !== '0) zero_bad = 1;
                    if (msg_ready !== 1'b0) rdy_bad = 1;
                    tick();
                    n++;
                end
                check_int({nm, " hash_valid within bound"}, int'(n < BOUND), 1);
                check_int({nm, " hash_out zero before valid"}, int'(zero_bad), 0);
                check_int({nm, " msg_ready low while busy"}, int'(rdy_bad), 0);
                lat = cyc - first_acc;
                if (l4 == 0) begin
                    l4 = lat;
                    check_int({nm, " latency exceeds overhead"}, int'(lat > 4), 1);
                end else begin
                    check_int({nm, " latency"}, lat, nblk * l4 + nblk - 1);
                end
                check({nm, " digest"}, hash_out, exp);
            end
        end
        if (handshake) begin
            hash_ready = 1'b1;
            tick();
            hash_ready = 1'b0;
            check_int({nm, " hash_valid after handshake"}, int'(hash_valid), 0);
            check({nm, " hash_out after handshake"}, hash_out, '0);
            check_int({nm, " msg_ready after handshake"}, int'(msg_ready), 1);
        end
    endtask

    typedef struct {
        int unsigned        nblk;
        logic [2:0][N-1:0]  blk;
        logic [N-1:0]       exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [N-1:0]      pm1, maxv, y, exp0, exp_y;
        logic [2:0][N-1:0] b;
        int                acc;

        pm1  = P - 1;
        maxv = {N{1'b1}};
        for (int i = 0; i < 10; i++) begin
            vecs[i].nblk = 1;
            vecs[i].blk  = '0;
        end
        vecs[1].blk[0] = P;
        vecs[2].blk[0] = pm1;
        vecs[3].nblk   = 3;
        vecs[3].blk[0] = TEST_IN;
        vecs[3].blk[1] = TEST_KEY;
        vecs[3].blk[2] = 1;
        vecs[4].blk[0] = maxv;
        for (int i = 5; i < 10; i++) begin
            vecs[i].nblk = $urandom_range(1, 2);
            for (int j = 0; j < 3; j++) vecs[i].blk[j] = rand_fe();
        end
        for (int i = 0; i < 10; i++) vecs[i].exp = hash_of(vecs[i].blk, int'(vecs[i].nblk));
        exp0 = vecs[0].exp;

        rst        = 1'b1;
        msg_valid  = 1'b0;
        msg_data   = '0;
        msg_last   = 1'b0;
        hash_ready = 1'b0;
        repeat (3) tick();
        check_int("reset msg_ready", int'(msg_ready), 0);
        check_int("reset hash_valid", int'(hash_valid), 0);
        check("reset hash_out", hash_out, '0);
        rst = 1'b0;
        #1;
        check_int("msg_ready before first edge", int'(msg_ready), 0);
        tick();
        check_int("msg_ready after first edge", int'(msg_ready), 1);

        for (int i = 0; i < 10; i++)
            run_message($sformatf("vec%0d", i), vecs[i].blk, int'(vecs[i].nblk), vecs[i].exp, 1'b1);
        check("m=PRIME equals m=0 digest", vecs[1].exp, exp0);

        // backpressure: digest held for 20 cycles while a new block is offered
        b = '0;
        b[0] = rand_fe();
        run_message("bp first", b, 1, hash_of(b, 1), 1'b0);
        y = rand_fe();
        msg_valid = 1'b1;
        msg_data  = y;
        msg_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_int("bp hash_valid held", int'(hash_valid), 1);
            check("bp hash_out held", hash_out, hash_of(b, 1));
            check_int("bp msg_ready low", int'(msg_ready), 0);
        end
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        check_int("bp release hash_valid", int'(hash_valid), 0);
        check_int("bp release msg_ready", int'(msg_ready), 1);
        b = '0;
        b[0] = y;
        exp_y = hash_of(b, 1);
        run_message("bp next", b, 1, exp_y, 1'b1);

        // reset in RUN cycle 3 of the second block
        send_block(rand_fe(), 1'b0, acc);
        for (int n = 0; n < BOUND && !msg_ready; n++) tick();
        send_block(rand_fe(), 1'b1, acc);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_int("midrun rst msg_ready", int'(msg_ready), 0);
        check_int("midrun rst hash_valid", int'(hash_valid), 0);
        check("midrun rst hash_out", hash_out, '0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        b = '0;
        run_message("after reset m=0", b, 1, exp0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
